// File: rtl/button_pkg.sv
// Shared types for the push-button front end.
package button_pkg;
   typedef enum logic {IDLE, OFFER} arb_state_t;
endpackage

// File: rtl/input_debouncer.sv
// One raw input: 2-flop synchronizer, then a level that only flips after
// DEBOUNCE_CYCLES consecutive disagreeing samples.
module input_debouncer #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic CLK,
   input  logic RST,
   input  logic raw_in,
   output logic level_out
);
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q, level_q;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_in;
         sync2_q <= sync1_q;
         // any agreeing sample restarts the count, so short glitches never land
         if (sync2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_MAX) begin
            level_q <= sync2_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   assign level_out = level_q;
endmodule

// File: rtl/button_event_arbiter.sv
// Debounced button presses become one-shot pending requests, served
// round-robin to a single consumer over valid/ready.
module button_event_arbiter
   import button_pkg::*;
#(
   parameter  int N_INPUTS        = 4,
   parameter  int DEBOUNCE_CYCLES = 16,
   localparam int IDX_W           = $clog2(N_INPUTS)
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [N_INPUTS-1:0] buttons_in,
   output logic [N_INPUTS-1:0] pressed,
   output logic                event_valid,
   output logic [IDX_W-1:0]    event_id,
   input  logic                event_ready,
   output logic [N_INPUTS-1:0] overflow
);
   logic [N_INPUTS-1:0] level_w, pressed_d_q, rise;
   logic [N_INPUTS-1:0] pending_q, pending_d, overflow_q, overflow_d, clr;
   arb_state_t          state_q;
   logic                valid_q, accept, sel_found;
   logic [IDX_W-1:0]    id_q, rr_q, sel_idx;

   for (genvar g = 0; g < N_INPUTS; g++) begin : g_deb
      input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .CLK       (CLK),
         .RST       (RST),
         .raw_in    (buttons_in[g]),
         .level_out (level_w[g])
      );
   end

   assign rise   = level_w & ~pressed_d_q;
   assign accept = valid_q & event_ready;

   // a rise on the accepted id wins over the clear, and is not an overflow
   always_comb begin
      clr = '0;
      for (int i = 0; i < N_INPUTS; i++)
         clr[i] = accept && (id_q == IDX_W'(i));
      pending_d  = (pending_q & ~clr) | rise;
      overflow_d = overflow_q | (rise & pending_q & ~clr);
   end

   // first pending bit at or after rr_q, wrapping
   always_comb begin
      int               j;
      logic [IDX_W-1:0] j_idx;
      j         = 0;
      j_idx     = '0;
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = 0; k < N_INPUTS; k++) begin
         j = int'(rr_q) + k;
         if (j >= N_INPUTS) j = j - N_INPUTS;
         j_idx = j[IDX_W-1:0];
         if (!sel_found && pending_q[j_idx]) begin
            sel_found = 1'b1;
            sel_idx   = j_idx;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         pressed_d_q <= '0;
         pending_q   <= '0;
         overflow_q  <= '0;
      end else begin
         pressed_d_q <= level_w;
         pending_q   <= pending_d;
         overflow_q  <= overflow_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         id_q    <= '0;
         rr_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (sel_found) begin
                  id_q    <= sel_idx;
                  valid_q <= 1'b1;
                  state_q <= OFFER;
               end
            end
            OFFER: begin
               if (event_ready) begin
                  valid_q <= 1'b0;
                  rr_q    <= (id_q == IDX_W'(N_INPUTS - 1)) ? '0 : id_q + IDX_W'(1);
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign pressed     = level_w;
   assign event_valid = valid_q;
   assign event_id    = id_q;
   assign overflow    = overflow_q;
endmodule

// File: doc/button_event_arbiter.md
Name: button_event_arbiter

Overview:
- Front end for the board's push-button and switch inputs.
- Takes N raw asynchronous inputs and synchronizes each with a 2-flop stage.
- Debounces each input with a per-input counter and turns each debounced press (rising edge) into a pending request.
- Grants pending requests one at a time, round-robin, to a single consumer over a valid/ready handshake. Downstream control logic sees clean, serialized, one-shot button events.

Parameters:
- N_INPUTS, 4: number of raw inputs; must be 2 or more.
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronized input must differ from its stable level before the stable level flips; must be 2 or more.
- IDX_W, $clog2(N_INPUTS): localparam, width of the event index.

Ports:
- CLK, in, 1: single clock for the whole block.
- RST, in, 1: reset, synchronous, active-high.
- buttons_in, in, N_INPUTS: raw asynchronous inputs, 1 = pressed.
- pressed, out, N_INPUTS: debounced stable level per input.
- event_valid, out, 1: an event is offered.
- event_id, out, IDX_W: index of the offered input.
- event_ready, in, 1: consumer accepts the event.
- overflow, out, N_INPUTS: sticky flag per input; a press arrived while that input already had a pending event.

Behaviour:
- Clock and reset:
  - One clock (CLK). Reset (RST) is synchronous and active-high; all state updates on posedge CLK.
  - While RST is high at a clock edge: sync flops, counters, pressed, pending, overflow, event_valid, event_id and rr_ptr all go to 0; FSM goes to IDLE.
  - Reset during OFFER drops the offered event silently.
- Synchronizer: buttons_in[i] passes through two flops to give sync[i]. No other logic touches buttons_in.
- Debounce, per input:
  - If sync[i] == pressed[i]: cnt[i] <= 0.
  - Otherwise cnt[i] increments. When cnt[i] == DEBOUNCE_CYCLES-1 and the mismatch persists, pressed[i] <= sync[i] and cnt[i] <= 0.
  - Any mismatch gap resets the count, so glitches shorter than DEBOUNCE_CYCLES never reach pressed.
- Edge capture:
  - rise[i] = pressed[i] & ~pressed_d[i].
  - On rise[i], pending[i] <= 1.
  - If pending[i] is already 1 and is not being cleared in that cycle, overflow[i] <= 1 and pending stays 1.
  - Releases (falling edges) produce no event.
- Arbiter FSM, states IDLE and OFFER:
  - IDLE: if pending != 0, select the first set bit scanning from rr_ptr upward with wrap (rr_ptr, rr_ptr+1, ..., N_INPUTS-1, 0, ...). Register it into event_id, set event_valid <= 1, go to OFFER. Otherwise stay in IDLE with event_valid = 0.
  - OFFER: event_valid = 1 and event_id are held constant until the handshake.
  - When event_valid & event_ready: pending[event_id] <= 0, rr_ptr <= event_id+1 (wrapping to 0 after N_INPUTS-1), event_valid <= 0, return to IDLE.
  - One idle cycle always separates consecutive events, so maximum throughput is 1 event per 2 cycles.
- Simultaneous clear and set: if rise[event_id] occurs in the acceptance cycle, pending stays 1 (the new press is not lost) and no overflow is flagged.
- Latency: with a quiet consumer and idle FSM, event_valid rises 4+DEBOUNCE_CYCLES cycles after the first clock edge that samples the new buttons_in level:
  - 2 cycles for the synchronizer;
  - DEBOUNCE_CYCLES cycles for the debounce count;
  - 1 cycle to set pending;
  - 1 cycle for the arbiter.
- overflow clears only on RST.

Decomposition:
- Package button_pkg holds typedef enum logic {IDLE, OFFER} arb_state_t.
- Sub-module input_debouncer contains the 2-flop synchronizer, counter and stable level. It has parameter DEBOUNCE_CYCLES, ports CLK, RST, raw_in, level_out, and is instantiated N_INPUTS times in a generate loop.
- Edge capture, pending, overflow and the arbiter live in the top.

Test Plan (N_INPUTS=4, DEBOUNCE_CYCLES=4, event_ready held 1 unless stated):
- Clean press: buttons_in[2] goes 0->1 and is held → pressed[2]=1 after 6 cycles; event_valid=1 with event_id=2 after exactly 8 cycles; valid lasts 1 cycle; releasing produces no event.
- Glitch rejection: buttons_in[1] pulses high for 3 cycles, then low → pressed[1] stays 0, no event. A 4-cycle-wide pulse (measured after sync) → pressed[1] flips, one event with id 1.
- Round-robin: buttons_in=4'b1011 at once with event_ready held 1 → events with id 0, 1, 3 in that order, separated by one idle cycle. Then a fresh press on 0 and 3 together, with rr_ptr=0 → id 0 first, then id 3.
- Backpressure: event_ready=0 for 10 cycles while id 2 is offered → event_valid and event_id=2 stable throughout; raising event_ready → accepted in 1 cycle.
- Overflow and set/clear race: second debounced press of input 3 while its event is still held by event_ready=0 → overflow[3]=1 and only one event is delivered. A rise on the accepted id in the acceptance cycle → a second event for the same id follows and overflow stays 0.
- Reset mid-operation: assert RST for 1 cycle during OFFER → next cycle event_valid=0, pressed=0, overflow=0, pending=0. Held inputs re-debounce and produce an event 8 cycles after RST deasserts.
